// File: rtl/apb_sram_bridge.sv
// APB slave front-end for the single-port side (port 0) of the on-chip SRAM macro.
// Each hit transfer becomes one registered chip-select cycle. Reads insert the
// extra wait state that the macro's synchronous read output needs.
module apb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         paddr,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                sram_csb0,
  output logic                sram_web0,
  output logic [DATA_W/8-1:0] sram_wmask0,
  output logic [ADDR_W-1:0]   sram_addr0,
  output logic [DATA_W-1:0]   sram_din0,
  input  logic [DATA_W-1:0]   sram_dout0
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    DONE
  } state_t;

  state_t              state, nxt_state;
  logic                addr_hit;
  logic                nxt_csb, nxt_web, nxt_pready, nxt_pslverr;
  logic [DATA_W/8-1:0] nxt_wmask;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [DATA_W-1:0]   nxt_din, nxt_prdata;

  // Window decode: upper address bits must match the base, and the access must be word aligned.
  always_comb begin
    addr_hit = (paddr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) && (paddr[1:0] == 2'b00);
  end

  // Next state and next values of every registered output.
  // The chip select, the write enable and pready fall back to inactive unless a state drives them.
  // The address and data buses hold their last value.
  always_comb begin
    nxt_state   = state;
    nxt_csb     = 1'b1;
    nxt_web     = 1'b1;
    nxt_wmask   = '0;
    nxt_addr    = sram_addr0;
    nxt_din     = sram_din0;
    nxt_pready  = 1'b0;
    nxt_pslverr = 1'b0;
    nxt_prdata  = '0;
    unique case (state)
      IDLE: begin
        if (psel && !penable) begin
          if (addr_hit) begin
            nxt_state = ISSUE;
            nxt_csb   = 1'b0;
            nxt_web   = ~pwrite;
            nxt_addr  = paddr[ADDR_W+1:2];
            nxt_din   = pwdata;
            nxt_wmask = pwrite ? pstrb : '0;
          end else begin
            nxt_state   = DONE;
            nxt_pready  = 1'b1;
            nxt_pslverr = 1'b1;
          end
        end
      end
      ISSUE: begin
        // sram_web0 still carries the direction of the cycle the macro is sampling now
        if (!sram_web0) begin
          nxt_state  = DONE;
          nxt_pready = 1'b1;
        end else begin
          nxt_state = CAPT;
        end
      end
      CAPT: begin
        // the read data is captured straight into prdata, which is presented during DONE
        nxt_state  = DONE;
        nxt_pready = 1'b1;
        nxt_prdata = sram_dout0;
      end
      DONE: begin
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State and output registers; reset takes effect asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      pready      <= 1'b0;
      pslverr     <= 1'b0;
      prdata      <= '0;
    end else begin
      state       <= nxt_state;
      sram_csb0   <= nxt_csb;
      sram_web0   <= nxt_web;
      sram_wmask0 <= nxt_wmask;
      sram_addr0  <= nxt_addr;
      sram_din0   <= nxt_din;
      pready      <= nxt_pready;
      pslverr     <= nxt_pslverr;
      prdata      <= nxt_prdata;
    end
  end

endmodule

// File: doc/apb_sram_bridge.md
# apb_sram_bridge

APB slave front-end for the SoC's on-chip sky130 1 KB SRAM macro (32 x 256, 1RW+1R). It sits directly upstream of the macro's RW port 0. It converts APB setup/access transfers into single registered chip-select cycles on that port, inserting the wait states the macro's synchronous read needs. The macro's read-only port 1 is outside this block.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte base of the SRAM window. Must be aligned to 2^(ADDR_W+2).
- ADDR_W, 8: SRAM word-address width. The window spans 2^(ADDR_W+2) bytes.
- DATA_W, 32: data width. Fixed at 32; wmask is DATA_W/8 bits.

Ports:
- clk  in  1: single clock for APB and SRAM port 0.
- rst_n  in  1: asynchronous, active-low reset.
- paddr  in  32: APB byte address.
- psel  in  1: APB select.
- penable  in  1: APB enable.
- pwrite  in  1: 1 = write.
- pwdata  in  32: write data.
- pstrb  in  4: byte strobes; bit i maps to byte lane i.
- prdata  out  32: read data.
- pready  out  1: transfer complete.
- pslverr  out  1: error response.
- sram_csb0  out  1: port-0 chip select, active low.
- sram_web0  out  1: port-0 write enable, active low.
- sram_wmask0  out  4: port-0 byte write mask.
- sram_addr0  out  ADDR_W: port-0 word address.
- sram_din0  out  32: port-0 write data.
- sram_dout0  in  32: port-0 read data. Valid in the cycle after the edge that sampled csb0=0.

## Operation
- All outputs are registered.
- Reset values:
  - sram_csb0=1, sram_web0=1.
  - sram_wmask0=0, sram_addr0=0, sram_din0=0.
  - pready=0, pslverr=0, prdata=0.
- FSM states: IDLE, ISSUE, CAPT, DONE.
- IDLE: on psel=1 and penable=0 (setup phase), decode the address:
  - Hit: paddr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2] and paddr[1:0]==0.
  - Hit → ISSUE. Register:
    - csb0=0
    - web0=~pwrite
    - addr0=paddr[ADDR_W+1:2]
    - din0=pwdata
    - wmask0=pwrite ? pstrb : 0
  - Miss (out of window or misaligned) → DONE with err=1. The SRAM is not touched.
- ISSUE (one cycle, SRAM samples at the closing edge):
  - Drive csb0=1, web0=1, wmask0=0.
  - Write → DONE. Read → CAPT.
- CAPT: at the closing edge, prdata_q <= sram_dout0, then → DONE.
- DONE (one cycle):
  - pready=1.
  - pslverr=err.
  - prdata=prdata_q for error-free reads; otherwise prdata=0.
  - Next state → IDLE; pready, pslverr and prdata return to 0.
- Write with pstrb=0: a normal SRAM cycle with wmask0=0 (memory unchanged) and pslverr=0.
- psel deasserted mid-transfer (APB violation): the FSM still completes its sequence and pulses pready. No abort.
- Asynchronous reset mid-transfer: all outputs immediately take their reset values (csb0=1) and the FSM goes to IDLE. Any in-flight write has undefined effect on that word.

## Timing
- Let S be the setup cycle and A1, A2, A3 the access cycles.
- Write: csb0=0 in A1; pready=1 in A2. Transfer = 3 cycles.
- Read: csb0=0 in A1; dout valid in A2; pready=1 with prdata in A3. Transfer = 4 cycles.
- Error: pready=1 and pslverr=1 in A1. Transfer = 2 cycles.
- Back-to-back: the cycle after DONE may be the next setup cycle; IDLE accepts it with no bubble.
- sram_csb0 is low for exactly one cycle per hit transfer. Its low pulse never overlaps pready=1.
- pready is high for exactly one cycle per transfer and is never high while the FSM is in IDLE.

## Test plan
- Reset: hold rst_n=0 with psel toggling → csb0=1, web0=1, pready=0, prdata=0 throughout.
- Write then read:
  - Write 0xDEADBEEF to 0x10 with pstrb=F → in A1, csb0=0, web0=0, addr0=4, din0=0xDEADBEEF, wmask0=F; pready in A2.
  - Read 0x10 → prdata=0xDEADBEEF with pready in A3, pslverr=0.
- Byte strobes: write 0x11223344 to 0x20 with pstrb=4'b0101 over 0xFFFFFFFF → a later read returns 0xFF22FF44.
- Errors: access to 0x400 (out of window) or to 0x13 (misaligned) → pready=1 and pslverr=1 in A1, csb0 never low, prdata=0.
- Back-to-back plus reset:
  - Three reads with no idle cycles return the correct data in the correct order.
  - Asserting rst_n=0 during ISSUE of a write forces csb0=1 within the same cycle and leaves the FSM in IDLE after release.
